// File: rtl/lfsr_delay_timer.sv
// Random-delay timer: captures a 7-bit LFSR value plus MIN_DELAY on trigger, counts ticks, then holds time_out until ack.
// Optional build macro LFSR_FREERUN_EN: LFSR shifts every clock instead of only on tick.
module lfsr_delay_timer #(
  parameter int unsigned MIN_DELAY = 8,
  parameter logic [6:0]  LFSR_SEED = 7'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       trigger,
  input  logic       ack,
  input  logic       abort,
  output logic       time_out,
  output logic       busy,
  output logic [7:0] delay_value
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_ILLEGAL = 2'd3
  } state_t;

  localparam logic [7:0] MIN_DELAY_8 = 8'(MIN_DELAY);

  state_t     r_state;
  logic [6:0] r_lfsr;
  logic [7:0] r_count;
  logic [7:0] r_delay;
  logic       r_time_out;
  logic       r_busy;

  logic [6:0] w_lfsr_next;
  logic       w_lfsr_shift;
  logic [7:0] w_load;

  // x^7 + x^6 + 1, never reaches zero from a non-zero seed
  assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

`ifdef LFSR_FREERUN_EN
  assign w_lfsr_shift = 1'b1;
`else
  assign w_lfsr_shift = tick;
`endif

  // Capture uses the pre-shift LFSR value of the trigger edge
  assign w_load = {1'b0, r_lfsr} + MIN_DELAY_8;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_lfsr_shift) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= 8'd0;
      r_delay    <= 8'd0;
      r_time_out <= 1'b0;
      r_busy     <= 1'b0;
    end else if (abort) begin
      // Abort beats a coincident final tick; count and delay are retained
      r_state    <= S_IDLE;
      r_time_out <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trigger) begin
            r_count <= w_load;
            r_delay <= w_load;
            if (w_load == 8'd0) begin
              r_state    <= S_DONE;
              r_time_out <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state    <= S_WAIT;
              r_time_out <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (r_count <= 8'd1) begin
              r_state    <= S_DONE;
              r_time_out <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_count <= r_count - 8'd1;
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            r_state    <= S_IDLE;
            r_time_out <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_time_out <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign time_out    = r_time_out;
  assign busy        = r_busy;
  assign delay_value = r_delay;

endmodule

// File: tb/tb_lfsr_delay_timer.sv
// Directed bench for lfsr_delay_timer with an LFSR reference model and a delay-value scoreboard.
module tb_lfsr_delay_timer;

  localparam int unsigned MIN_DELAY = 8;
  localparam logic [6:0]  SEED      = 7'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       trigger = 1'b0;
  logic       ack = 1'b0;
  logic       abort = 1'b0;
  logic       time_out;
  logic       busy;
  logic [7:0] delay_value;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [6:0] m_q = SEED;
  logic [7:0] exp_q[$];
  logic [7:0] cur_delay;
  logic [7:0] held_delay;

  lfsr_delay_timer #(.MIN_DELAY(MIN_DELAY), .LFSR_SEED(SEED)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .trigger     (trigger),
    .ack         (ack),
    .abort       (abort),
    .time_out    (time_out),
    .busy        (busy),
    .delay_value (delay_value)
  );

  always #5 clk = ~clk;

  // One clock edge; the reference LFSR advances using the inputs present at that edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) m_q = SEED;
`ifdef LFSR_FREERUN_EN
    else m_q = {m_q[5:0], m_q[6] ^ m_q[5]};
`else
    else if (tick) m_q = {m_q[5:0], m_q[6] ^ m_q[5]};
`endif
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Drive trigger for one edge and queue the delay the model predicts.
  task automatic fire(input logic with_tick);
    exp_q.push_back(8'({1'b0, m_q}) + 8'(MIN_DELAY));
    trigger = 1'b1;
    tick    = with_tick;
    cyc();
    trigger = 1'b0;
    tick    = 1'b0;
    cur_delay = exp_q.pop_front();
    chk("load_delay", delay_value, cur_delay);
    chk("load_busy", {7'd0, busy}, 8'd1);
  endtask

  // Issue n ticks in WAIT (trigger held to confirm it is ignored); last one must finish.
  task automatic run_ticks(input int n);
    for (int i = 1; i <= n; i++) begin
      tick    = 1'b1;
      trigger = 1'b1;
      cyc();
      tick    = 1'b0;
      trigger = 1'b0;
      if (i < n) begin
        if (i % 4 == 1) chk("wait_busy", {7'd0, busy}, 8'd1);
        chk("wait_timeout", {7'd0, time_out}, 8'd0);
      end else begin
        chk("done_timeout", {7'd0, time_out}, 8'd1);
        chk("done_busy", {7'd0, busy}, 8'd0);
        chk("done_delay_kept", delay_value, cur_delay);
      end
      cyc();
    end
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst_timeout", {7'd0, time_out}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_delay", delay_value, 8'd0);
    rst = 1'b0;

    // First trigger after reset captures the seed value: 1 + 8
    fire(1'b0);
    chk("first_delay_9", delay_value, 8'd9);
    run_ticks(int'(cur_delay));

    // ack and trigger together: ack wins, then a held trigger starts anew
    cyc();
    chk("done_holds", {7'd0, time_out}, 8'd1);
    trigger = 1'b1;
    ack     = 1'b1;
    cyc();
    ack = 1'b0;
    chk("ack_timeout", {7'd0, time_out}, 8'd0);
    chk("ack_idle_busy", {7'd0, busy}, 8'd0);
    held_delay = cur_delay;
    fire(1'b0);
    if (cur_delay == held_delay) chk("new_delay_differs", delay_value, held_delay + 8'd1);

    // Abort race: drive down to count 1, then final tick with abort
    for (int i = 1; i < int'(cur_delay); i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    chk("pre_race_busy", {7'd0, busy}, 8'd1);
    tick  = 1'b1;
    abort = 1'b1;
    cyc();
    tick  = 1'b0;
    abort = 1'b0;
    chk("race_timeout", {7'd0, time_out}, 8'd0);
    chk("race_busy", {7'd0, busy}, 8'd0);
    chk("race_delay_kept", delay_value, cur_delay);
    cyc();
    chk("race_timeout2", {7'd0, time_out}, 8'd0);

    // Three ticks in IDLE advance the LFSR before the next capture
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    chk("idle_busy", {7'd0, busy}, 8'd0);
    // A tick in the load cycle is not counted
    fire(1'b1);
    run_ticks(int'(cur_delay));

    // Abort from DONE
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_done_to", {7'd0, time_out}, 8'd0);
    chk("abort_done_dly", delay_value, cur_delay);

    // Asynchronous reset in the middle of WAIT
    fire(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
    #2;
    rst = 1'b1;
    m_q = SEED;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_timeout", {7'd0, time_out}, 8'd0);
    chk("arst_delay", delay_value, 8'd0);
    cyc();
    rst = 1'b0;
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    fire(1'b0);
    chk("post_rst_delay9", delay_value, 8'd9);
    run_ticks(int'(cur_delay));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
